// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//
// Bit-serial N-bit adder. A single full-adder cell is reused for every bit
// position, LSB first, one bit per clock. This block owns the operand shift
// registers, the carry flip-flop, the sum shift register and the bit counter,
// and wraps them in a start/busy/done handshake.
//
// Handshake: start is a request sampled on each rising edge and is accepted
// only when the controller is IDLE or DONE (start while busy is dropped, not
// queued); a, b and cin are captured on that accepting edge and may change
// afterwards; busy is high for exactly N cycles while the bits are processed;
// done is a one-cycle pulse that is never coincident with busy, and sum, cout
// and ovf are valid from the done cycle on and hold until the next done.

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    // Counter width: ceil(log2 N); N is at least 2 so this is at least 1.
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Controller state. Kept as a named signal so checkers and debug views
    // can observe it directly in the hierarchy.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Datapath storage.
    logic [N-1:0]  sa;       // operand A, shifted right one bit per step
    logic [N-1:0]  sb;       // operand B, shifted right one bit per step
    logic          c;        // running carry into the current bit
    logic [CW-1:0] cnt;      // index of the bit being processed
    logic [N-1:0]  sreg;     // partial sum, filled from the MSB end
    logic [N-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    // Control decode.
    logic          accept;     // this edge starts a new operation
    logic          step;       // this edge performs one bit-step
    logic          last_step;  // this edge processes the MSB
    logic          fa_sum;
    logic          fa_carry;
    logic [N-1:0]  sreg_next;

    // Request acceptance and per-edge step qualification.
    always_comb begin
        accept    = start && ((state == S_IDLE) || (state == S_DONE));
        step      = (state == S_RUN);
        last_step = step && (cnt == LAST);
    end

    // The one shared full-adder cell, fed by the LSBs of the operand
    // shift registers and the carry flip-flop.
    always_comb begin
        fa_sum   = sa[0] ^ sb[0] ^ c;
        fa_carry = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    end

    // New sum bit enters at the MSB; after N steps bit i has reached position i.
    always_comb begin
        sreg_next = {fa_sum, {(N-1){1'b0}}} | (sreg >> 1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_step ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from state only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand shift registers: load on accept, shift right on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
        end else if (accept) begin
            sa <= a;
            sb <= b;
        end else if (step) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
        end
    end

    // Carry flip-flop: seeded with cin, then follows the adder carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= 1'b0;
        end else if (accept) begin
            c <= cin;
        end else if (step) begin
            c <= fa_carry;
        end
    end

    // Bit counter: cleared on accept, holds at N-1 on the final step so it
    // never needs to represent N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (step && !last_step) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Partial-sum shift register: cleared on accept, one bit in per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= '0;
        end else if (step) begin
            sreg <= sreg_next;
        end
    end

    // Result registers: updated only on the MSB step. The carry flip-flop at
    // that step is the carry into bit N-1, so overflow is it XOR the final
    // carry out; accepting a new operation leaves the old results in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_step) begin
            sum_q  <= sreg_next;
            cout_q <= fa_carry;
            ovf_q  <= c ^ fa_carry;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // Structural invariants of the controller.
    a_no_busy_with_done : assert property (
        @(posedge clk) disable iff (!rst_n) !(busy && done)
    );

    a_state_legal : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == S_IDLE) || (state == S_RUN) || (state == S_DONE)
    );

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder. One full-adder cell (sum = a^b^c, carry = majority) is shared across all bit positions and sequenced LSB-first, one bit per clock. A controller owns the operand shift registers, the carry flip-flop and the bit counter, and exposes a start/busy/done handshake. It is the sequencing layer that turns the single full-adder datapath into a multi-bit adder while keeping the arithmetic unit to one cell.

## Interface
- N, default 8: operand/result width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- a  input  N  operand A; captured on the accepting edge.
- b  input  N  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (state RUN).
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle on.
- sum  output  N  result a+b+cin mod 2^N; registered.
- cout  output  1  carry out of bit N-1; registered.
- ovf  output  1  two's-complement overflow = carry into bit N-1 XOR carry out of bit N-1; registered.

## Operation
- State machine:
  - IDLE: start=1 -> RUN.
  - RUN: after N bit-steps -> DONE.
  - DONE: start=1 -> RUN, otherwise -> IDLE.
- Accepting edge (IDLE or DONE with start=1):
  - Load shift registers SA<=a and SB<=b.
  - Load carry flip-flop C<=cin.
  - Clear counter cnt<=0 and the sum shift register.
  - Result outputs are not cleared at this edge; they keep their previous values until DONE.
- RUN step (each edge while in RUN), one full-adder evaluation:
  - Inputs are SA[0], SB[0] and C.
  - The sum bit shifts into the sum register from the MSB end, so after N steps bit i sits at position i.
  - C<=carry; SA and SB shift right by one.
  - The step with cnt=N-1 also stores cprev<=C, the carry into the MSB.
  - cnt increments by one per step.
- Leaving RUN (step cnt=N-1):
  - Transfer the sum register to sum.
  - cout<=final carry; ovf<=cprev XOR final carry.
  - Go to DONE.
- start during RUN is ignored; it is neither queued nor does it disturb the operation in progress.
- a, b and cin may change freely after the accepting edge.
- Results hold indefinitely in IDLE and change only on the next DONE.
- Width rules:
  - cnt is ceil(log2 N) bits; the terminal count compares cnt to N-1, with no wrap.
  - sum wraps mod 2^N; the lost carry appears only on cout.

## Timing
- Reset (rst_n=0, asynchronous, any state, including mid-RUN):
  - State goes to IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; cnt, C and the shift registers are cleared.
  - An aborted operation produces no done.
  - The first edge after rst_n rises may accept start.
- Latency: accepting edge E0, then busy=1 for cycles E0+1 through E0+N (N cycles).
- done=1 and busy=0 in the single cycle after edge E0+N; the results are already updated in that cycle.
- Back-to-back: start=1 during the done cycle is accepted. The next busy begins immediately, giving a throughput of one result per N+1 cycles.
- done is never high in the same cycle as busy.

## Test plan
- Reset then idle: rst_n low for 2 cycles mid-run -> busy=0, done=0, sum=0x00, cout=0, ovf=0. No done for 20 cycles with start=0.
- N=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy for exactly 8 cycles, then done for 1 cycle with sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- start held high for the whole operation, with a/b changed to 0x00 after acceptance -> only one operation runs, result is computed from the captured operands, and no restart happens before done.
- Back-to-back: start in the done cycle with a=0x80, b=0x80, cin=0 -> second done 9 cycles after the first, with sum=0x00, cout=1, ovf=1.
- rst_n asserted in the cycle after bit 4 completes -> outputs are 0 immediately without waiting for a clock edge. A subsequent start with 0x01+0x01 gives sum=0x02 after 8 busy cycles.
